// File: rtl/inst_fetch_unit.sv
// Instruction fetch front-end: turns the core's per-cycle address stream into
// req/gnt/rvalid reads, keeps one word for the core and prefetches the next one.
module inst_fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INST       = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] boot_addr,
    input  logic [31:0] inst_addr,
    output logic [31:0] instruction,
    output logic        inst_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_err
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_READY, S_DRAIN} state_t;
    typedef enum logic [1:0] {PF_NONE, PF_REQ, PF_WAIT, PF_DONE} pf_t;

    state_t      state_q, state_d;
    pf_t         pf_st_q, pf_st_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [31:0] cur_data_q, cur_data_d;
    logic [31:0] pf_addr_q, pf_addr_d;
    logic [31:0] pf_data_q, pf_data_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_q, err_d;

    logic [16:0] tmo_inc;
    logic        tmo_hit;
    logic        pf_issuing;
    logic        pf_granted;
    logic        pf_done_now;
    logic        addr_match;
    logic        misaligned;
    logic [31:0] pf_rdata;

    assign tmo_inc     = {1'b0, tmo_cnt_q} + 17'd1;
    assign tmo_hit     = (tmo_inc >= 17'(TIMEOUT_CYCLES));

    assign pf_issuing  = (state_q == S_READY) && ((pf_st_q == PF_NONE) || (pf_st_q == PF_REQ));
    // Granted but data not yet back at this edge: the transaction is still in flight.
    assign pf_granted  = (pf_issuing && imem_gnt) || ((pf_st_q == PF_WAIT) && !imem_rvalid);
    assign pf_done_now = (pf_st_q == PF_DONE) || ((pf_st_q == PF_WAIT) && imem_rvalid);
    assign pf_rdata    = (pf_st_q == PF_DONE) ? pf_data_q : imem_rdata;
    assign addr_match  = (inst_addr == pf_addr_q);
    assign misaligned  = (inst_addr[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        pf_st_d    = pf_st_q;
        cur_addr_d = cur_addr_q;
        cur_data_d = cur_data_q;
        pf_addr_d  = pf_addr_q;
        pf_data_d  = pf_data_q;
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d    = S_REQ;
                cur_addr_d = boot_addr;
                pf_addr_d  = boot_addr + 32'd4;
                pf_st_d    = PF_NONE;
            end
            S_REQ: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end else if (tmo_hit) begin
                    state_d    = S_READY;
                    cur_data_d = NOP_INST;
                    err_d      = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_inc[15:0];
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d    = S_READY;
                    cur_data_d = imem_rdata;
                end else if (tmo_hit) begin
                    state_d    = S_READY;
                    cur_data_d = NOP_INST;
                    err_d      = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_inc[15:0];
                end
            end
            S_DRAIN: begin
                if (imem_rvalid || tmo_hit) begin
                    state_d = S_REQ;
                end else begin
                    tmo_cnt_d = tmo_inc[15:0];
                end
            end
            S_READY: begin
                if (misaligned) begin
                    // cur_addr is kept, so the cur_addr+4 prefetch stays relevant and keeps running.
                    cur_data_d = NOP_INST;
                    err_d      = 1'b1;
                    case (pf_st_q)
                        PF_NONE, PF_REQ: pf_st_d = imem_gnt ? PF_WAIT : PF_REQ;
                        PF_WAIT: begin
                            if (imem_rvalid) begin
                                pf_st_d   = PF_DONE;
                                pf_data_d = imem_rdata;
                            end
                        end
                        default: pf_st_d = pf_st_q;
                    endcase
                end else begin
                    cur_addr_d = inst_addr;
                    pf_addr_d  = inst_addr + 32'd4;
                    pf_st_d    = PF_NONE;
                    if (addr_match && pf_done_now) begin
                        cur_data_d = pf_rdata;
                    end else if (addr_match && pf_granted) begin
                        state_d = S_WAIT;
                    end else if (pf_granted) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pf_st_q    <= PF_NONE;
            cur_addr_q <= '0;
            cur_data_q <= NOP_INST;
            pf_addr_q  <= '0;
            pf_data_q  <= '0;
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pf_st_q    <= pf_st_d;
            cur_addr_q <= cur_addr_d;
            cur_data_q <= cur_data_d;
            pf_addr_q  <= pf_addr_d;
            pf_data_q  <= pf_data_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
        end
    end

    assign inst_ready  = (state_q == S_READY);
    assign instruction = cur_data_q;
    assign fetch_err   = err_q;
    assign imem_req    = (state_q == S_REQ) || pf_issuing;

    always_comb begin
        imem_addr = '0;
        if (state_q == S_REQ) begin
            imem_addr = {cur_addr_q[31:2], 2'b00};
        end else if (pf_issuing) begin
            imem_addr = {pf_addr_q[31:2], 2'b00};
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: random core address stream and a
// random-latency memory; expected words come from the memory contents directly.
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned TMO = 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] boot_addr = 32'h0000_0100;
    logic [31:0] inst_addr = '0;
    logic [31:0] instruction;
    logic        inst_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        fetch_err;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned delivered = 0;
    int unsigned gnt_count = 0;
    int unsigned seq_pct = 60;
    bit          stall = 1'b0;
    bit          outstanding = 1'b0;
    exp_t        sb[$];

    inst_fetch_unit #(
        .TIMEOUT_CYCLES(TMO),
        .NOP_INST      (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .boot_addr  (boot_addr),
        .inst_addr  (inst_addr),
        .instruction(instruction),
        .inst_ready (inst_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: grant after 0..2 extra request cycles, data 1..3 edges after grant.
    always @(negedge clk) begin : mem_model
        int unsigned req_cnt;
        int unsigned gdelay;
        int unsigned rv_wait;
        logic [31:0] gnt_addr;
        logic [31:0] rv_addr;
        if (rst) begin
            outstanding = 1'b0;
            req_cnt     = 0;
            gdelay      = 0;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
        end else begin
            if (imem_rvalid) outstanding = 1'b0;
            if (imem_gnt) begin
                outstanding = 1'b1;
                rv_addr     = gnt_addr;
                rv_wait     = $urandom_range(0, 2);
            end
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (outstanding) begin
                if (rv_wait == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memf(rv_addr);
                end else begin
                    rv_wait--;
                end
            end
            if (imem_req) begin
                vectors++;
                if (imem_addr[1:0] != 2'b00 || outstanding) begin
                    miscompares++;
                    $display("FAIL req_protocol: addr %h outstanding %0d at %0t", imem_addr, outstanding, $time);
                end
                if (!stall) begin
                    if (req_cnt >= gdelay) begin
                        imem_gnt = 1'b1;
                        gnt_addr = imem_addr;
                        gnt_count++;
                        req_cnt  = 0;
                        gdelay   = $urandom_range(0, 2);
                    end else begin
                        req_cnt++;
                    end
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    // Core model: picks the next address on every inst_ready cycle and records what it must receive.
    always @(negedge clk) begin : core_driver
        logic [31:0] last_addr;
        logic [31:0] a;
        int unsigned r;
        if (rst) begin
            last_addr = boot_addr;
        end else if (inst_ready) begin
            r = $urandom_range(0, 99);
            if (r < seq_pct) a = last_addr + 32'd4;
            else if (r < seq_pct + 10) a = last_addr;
            else if (r < seq_pct + 25) a = 32'h0000_0100 + ($urandom_range(0, 255) << 2);
            else a = 32'h0000_0100 + ($urandom_range(0, 255) << 2) + $urandom_range(1, 3);
            inst_addr = a;
            if (a[1:0] != 2'b00) begin
                sb.push_back('{NOP, 1'b1});
            end else begin
                last_addr = a;
                sb.push_back('{stall ? NOP : memf(a), stall});
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (inst_ready) begin
                delivered++;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_delivery: got %h expected none", instruction);
                end else begin
                    e = sb.pop_front();
                    chk("instruction", instruction, e.data);
                    chk("fetch_err", {31'b0, fetch_err}, {31'b0, e.err});
                end
            end else if (fetch_err) begin
                vectors++;
                miscompares++;
                $display("FAIL err_outside_ready: got 1 expected 0 at %0t", $time);
            end
        end
    end

    int unsigned g0, d0;

    task automatic restart(input logic [31:0] boot, input bit stl);
        int unsigned nreq;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_inst_ready", {31'b0, inst_ready}, 32'd0);
        chk("rst_instruction", instruction, NOP);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        sb.delete();
        stall     = stl;
        boot_addr = boot;
        g0        = gnt_count;
        d0        = delivered;
        sb.push_back('{stl ? NOP : memf(boot), stl});
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, boot);
        if (stl) begin
            nreq = 0;
            for (int c = 0; c < 20 && !inst_ready; c++) begin
                if (imem_req) nreq++;
                @(negedge clk);
            end
            chk("timeout_req_cycles", nreq, TMO);
        end
    endtask

    task automatic run_for(input int unsigned n);
        int unsigned target;
        int unsigned c;
        target = delivered + n;
        c = 0;
        while (delivered < target && c < 5000) begin
            @(negedge clk);
            c++;
        end
        if (delivered < target) begin
            vectors++;
            miscompares++;
            $display("FAIL delivery_budget: got %0d expected %0d", delivered, target);
        end
    endtask

    initial begin : main
        bit found;
        int unsigned n, g;

        seq_pct = 60;
        restart(32'h0000_0100, 1'b0);
        run_for(300);

        // Assert reset asynchronously while a read is in flight.
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            #1;
            if (outstanding && !inst_ready && !imem_req) found = 1'b1;
        end
        chk("found_inflight", {31'b0, found}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_inst_ready", {31'b0, inst_ready}, 32'd0);
        chk("async_instruction", instruction, NOP);
        chk("async_imem_req", {31'b0, imem_req}, 32'd0);
        chk("async_imem_addr", imem_addr, 32'd0);
        chk("async_fetch_err", {31'b0, fetch_err}, 32'd0);
        restart(32'h0000_0200, 1'b0);
        run_for(40);

        // Purely sequential stream across the 32-bit wrap: every word fetched exactly once.
        seq_pct = 100;
        restart(32'hFFFF_FFE0, 1'b0);
        run_for(60);
        #1;
        n = delivered - d0;
        g = gnt_count - g0;
        chk("seq_fetch_once", {31'b0, (g == n) || (g == n + 1)}, 32'd1);

        seq_pct = 60;
        restart(32'h0000_0300, 1'b1);
        run_for(10);

        rst = 1'b1;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
